// File: rtl/led_pwm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : led_pwm_pkg
//  Description : Register map and STATUS field layout for the LED PWM PIO.
//  Revision    : 1.0  initial release
// ============================================================================
package led_pwm_pkg;

    // Word addresses on the slave port
    localparam logic [5:0] ADDR_DATA        = 6'h00;
    localparam logic [5:0] ADDR_SET         = 6'h01;
    localparam logic [5:0] ADDR_CLR         = 6'h02;
    localparam logic [5:0] ADDR_BLINK       = 6'h03;
    localparam logic [5:0] ADDR_PRESC       = 6'h04;
    localparam logic [5:0] ADDR_BHALF       = 6'h05;
    localparam logic [5:0] ADDR_STATUS      = 6'h07;
    localparam logic [5:0] ADDR_BRIGHT_BASE = 6'h20;

    // STATUS register field offsets
    localparam int STATUS_PHASE_BIT = 0;
    localparam int STATUS_PWM_LSB   = 8;

    // Word address of the brightness register for LED idx
    function automatic logic [5:0] bright_addr(input int idx);
        logic [5:0] v_off;
        v_off = idx[5:0];
        return ADDR_BRIGHT_BASE + v_off;
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_pwm_timebase.sv
`default_nettype none
// ============================================================================
//  Module      : led_pwm_timebase
//  Description : Tick prescaler, PWM frame counter and blink phase generator.
//  Revision    : 1.0  initial release
// ============================================================================
module led_pwm_timebase #(
    parameter int PWM_BITS   = 8,
    parameter int PRESCALE_W = 16,
    parameter int BLINK_W    = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [PRESCALE_W-1:0] i_prescale,
    input  logic                  i_prescale_wr,
    input  logic [BLINK_W-1:0]    i_blink_half,
    input  logic                  i_blink_half_wr,
    output logic [PWM_BITS-1:0]   o_pwm_cnt,
    output logic                  o_frame_end,
    output logic                  o_blink_phase
);

    logic [PRESCALE_W-1:0] r_pre_cnt;
    logic [PWM_BITS-1:0]   r_pwm_cnt;
    logic [BLINK_W-1:0]    r_frm_cnt;
    logic                  r_blink_phase;

    logic                  w_tick;
    logic                  w_frame_end;
    logic [BLINK_W-1:0]    w_half_m1;

    assign w_tick      = (r_pre_cnt == i_prescale);
    assign w_frame_end = w_tick && (r_pwm_cnt == {PWM_BITS{1'b1}});
    assign w_half_m1   = i_blink_half - BLINK_W'(1);

    // Prescaler: counts 0..PRESCALE; a new PRESCALE restarts it from 0 so a
    // smaller value can never be overrun
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pre_cnt <= '0;
        end else if (i_prescale_wr || w_tick) begin
            r_pre_cnt <= '0;
        end else begin
            r_pre_cnt <= r_pre_cnt + PRESCALE_W'(1);
        end
    end

    // PWM position within the frame, advancing once per tick
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pwm_cnt <= '0;
        end else if (w_tick) begin
            r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
        end
    end

    // Blink phase toggles every BLINK_HALF frames; BLINK_HALF=0 holds it at 1
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frm_cnt     <= '0;
            r_blink_phase <= 1'b1;
        end else if (i_blink_half_wr) begin
            r_frm_cnt     <= '0;
            r_blink_phase <= 1'b1;
        end else if (w_frame_end && (i_blink_half != '0)) begin
            if (r_frm_cnt == w_half_m1) begin
                r_frm_cnt     <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_frm_cnt     <= r_frm_cnt + BLINK_W'(1);
            end
        end
    end

    assign o_pwm_cnt     = r_pwm_cnt;
    assign o_frame_end   = w_frame_end;
    assign o_blink_phase = r_blink_phase;

endmodule
`default_nettype wire

// File: rtl/led_pwm_pio.sv
`default_nettype none
// ============================================================================
//  Module      : led_pwm_pio
//  Description : Avalon-MM LED port with per-LED PWM brightness, blink mask
//                and atomic set/clear; zero-wait-state, combinational reads.
//  Revision    : 1.0  initial release
// ============================================================================
module led_pwm_pio
    import led_pwm_pkg::*;
#(
    parameter int NUM_LEDS   = 8,
    parameter int PWM_BITS   = 8,
    parameter int PRESCALE_W = 16,
    parameter int BLINK_W    = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [5:0]          address,
    input  logic                chipselect,
    input  logic                write_n,
    input  logic [31:0]         writedata,
    output logic [31:0]         readdata,
    output logic [NUM_LEDS-1:0] out_port
);

    logic [NUM_LEDS-1:0]   r_data;
    logic [NUM_LEDS-1:0]   r_blink_mask;
    logic [PRESCALE_W-1:0] r_prescale;
    logic [BLINK_W-1:0]    r_blink_half;
    logic [PWM_BITS-1:0]   r_bright [NUM_LEDS];
    logic [NUM_LEDS-1:0]   r_out_port;

    logic                  w_wr;
    logic                  w_presc_wr;
    logic                  w_bhalf_wr;
    logic [PWM_BITS-1:0]   w_pwm_cnt;
    logic                  w_frame_end;
    logic                  w_blink_phase;
    logic [NUM_LEDS-1:0]   w_pwm_on;
    logic                  w_unused;

    assign w_wr       = chipselect && !write_n;
    assign w_presc_wr = w_wr && (address == ADDR_PRESC);
    assign w_bhalf_wr = w_wr && (address == ADDR_BHALF);

    // Frame end is exported for future interrupt use; not needed here
    assign w_unused = ^{writedata, w_frame_end};

    led_pwm_timebase #(
        .PWM_BITS   (PWM_BITS),
        .PRESCALE_W (PRESCALE_W),
        .BLINK_W    (BLINK_W)
    ) u_timebase (
        .clk             (clk),
        .reset_n         (reset_n),
        .i_prescale      (r_prescale),
        .i_prescale_wr   (w_presc_wr),
        .i_blink_half    (r_blink_half),
        .i_blink_half_wr (w_bhalf_wr),
        .o_pwm_cnt       (w_pwm_cnt),
        .o_frame_end     (w_frame_end),
        .o_blink_phase   (w_blink_phase)
    );

    // Control register file: DATA with atomic set/clear, mask and timing regs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data       <= '0;
            r_blink_mask <= '0;
            r_prescale   <= '0;
            r_blink_half <= '0;
        end else if (w_wr) begin
            case (address)
                ADDR_DATA:  r_data       <= writedata[NUM_LEDS-1:0];
                ADDR_SET:   r_data       <= r_data | writedata[NUM_LEDS-1:0];
                ADDR_CLR:   r_data       <= r_data & ~writedata[NUM_LEDS-1:0];
                ADDR_BLINK: r_blink_mask <= writedata[NUM_LEDS-1:0];
                ADDR_PRESC: r_prescale   <= writedata[PRESCALE_W-1:0];
                ADDR_BHALF: r_blink_half <= writedata[BLINK_W-1:0];
                default:    ;
            endcase
        end
    end

    // Per-LED brightness; resets to full so the block starts as a plain PIO
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                r_bright[i] <= '1;
            end
        end else begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (w_wr && (address == bright_addr(i))) begin
                    r_bright[i] <= writedata[PWM_BITS-1:0];
                end
            end
        end
    end

    // Zero-latency read mux; write-only and unmapped words read as 0
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:   readdata[NUM_LEDS-1:0]   = r_data;
            ADDR_BLINK:  readdata[NUM_LEDS-1:0]   = r_blink_mask;
            ADDR_PRESC:  readdata[PRESCALE_W-1:0] = r_prescale;
            ADDR_BHALF:  readdata[BLINK_W-1:0]    = r_blink_half;
            ADDR_STATUS: begin
                readdata[STATUS_PHASE_BIT]            = w_blink_phase;
                readdata[STATUS_PWM_LSB +: PWM_BITS]  = w_pwm_cnt;
            end
            default: begin
                for (int i = 0; i < NUM_LEDS; i++) begin
                    if (address == bright_addr(i)) begin
                        readdata[PWM_BITS-1:0] = r_bright[i];
                    end
                end
            end
        endcase
    end

    // PWM compare: all-ones brightness is steady on, zero is off
    always_comb begin
        w_pwm_on = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            w_pwm_on[i] = (r_bright[i] == {PWM_BITS{1'b1}}) || (w_pwm_cnt < r_bright[i]);
        end
    end

    // Registered LED drive combining enable, PWM and masked blink
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_port <= '0;
        end else begin
            r_out_port <= r_data & w_pwm_on & (~r_blink_mask | {NUM_LEDS{w_blink_phase}});
        end
    end

    assign out_port = r_out_port;

endmodule
`default_nettype wire

// File: tb/tb_led_pwm_pio.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_pwm_pio
//  Description : Directed self-checking bench for led_pwm_pio (8 LEDs).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_led_pwm_pio;

    logic        clk;
    logic        reset_n;
    logic [5:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;

    int n_vec = 0;
    int n_bad = 0;

    led_pwm_pio #(
        .NUM_LEDS   (8),
        .PWM_BITS   (8),
        .PRESCALE_W (16),
        .BLINK_W    (8)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Single-cycle write; returns 1 time unit after the write edge
    task automatic bus_write(input logic [5:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [5:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        d = readdata;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic [7:0]  p0;
        int          cnt;
        int          ntog;
        int          follow_err;
        int          tog_t [3];
        logic        prev_ph;
        logic        ph;
        bit          seen;

        reset_n    = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;

        // Reset state
        check("rst_out", {24'd0, out_port}, 32'h0);
        bus_read(6'h00, rd); check("rst_data", rd, 32'h0);
        bus_read(6'h20, rd); check("rst_bright0", rd, 32'hFF);
        bus_read(6'h07, rd); check("rst_phase", rd & 32'h1, 32'h1);

        // Plain PIO write with one-clock output latency
        bus_write(6'h00, 32'hA5);
        check("data_lat0", {24'd0, out_port}, 32'h0);
        @(posedge clk); #1;
        check("data_lat1", {24'd0, out_port}, 32'hA5);

        // Atomic set / clear
        bus_write(6'h00, 32'h0F);
        bus_write(6'h01, 32'hF0);
        bus_write(6'h02, 32'h03);
        bus_read(6'h00, rd); check("setclr_data", rd, 32'hFC);
        @(posedge clk); #1;
        check("setclr_out", {24'd0, out_port}, 32'hFC);
        bus_read(6'h01, rd); check("set_reads0", rd, 32'h0);
        bus_read(6'h02, rd); check("clr_reads0", rd, 32'h0);

        // PWM duty at PRESCALE=0: one PWM step per clock, 256-clock frame
        bus_write(6'h22, 32'd64);
        bus_write(6'h00, 32'h04);
        bus_read(6'h22, rd); check("bright2_rd", rd, 32'd64);
        repeat (3) @(posedge clk);
        cnt = 0;
        for (int k = 0; k < 256; k++) begin
            @(posedge clk); #1;
            cnt += int'(out_port[2]);
        end
        check("pwm64_duty", cnt, 32'd64);

        bus_write(6'h22, 32'd0);
        repeat (3) @(posedge clk);
        cnt = 0;
        for (int k = 0; k < 256; k++) begin
            @(posedge clk); #1;
            cnt += int'(out_port[2]);
        end
        check("pwm0_duty", cnt, 32'd0);

        bus_write(6'h22, 32'hFF);
        repeat (3) @(posedge clk);
        cnt = 0;
        for (int k = 0; k < 256; k++) begin
            @(posedge clk); #1;
            cnt += int'(out_port[2]);
        end
        check("pwmff_duty", cnt, 32'd256);

        // Blink: 4 clk/tick * 256 ticks * 2 frames = 2048 clk per half-period
        bus_write(6'h04, 32'd3);
        bus_write(6'h05, 32'd2);
        bus_read(6'h07, rd); check("bhalf_wr_phase", rd & 32'h1, 32'h1);
        bus_write(6'h03, 32'h01);
        bus_write(6'h00, 32'h01);
        bus_read(6'h07, rd);
        prev_ph    = rd[0];
        ntog       = 0;
        follow_err = 0;
        for (int k = 0; k < 9000 && ntog < 3; k++) begin
            @(posedge clk); #1;
            ph = readdata[0];
            if (out_port[0] !== prev_ph) follow_err++;
            if (ph !== prev_ph) begin
                tog_t[ntog] = k;
                ntog++;
            end
            prev_ph = ph;
        end
        check("blink_toggles", ntog, 32'd3);
        if (ntog == 3) begin
            check("blink_half1", tog_t[1] - tog_t[0], 32'd2048);
            check("blink_half2", tog_t[2] - tog_t[1], 32'd2048);
        end
        check("blink_follow_err", follow_err, 32'd0);

        // PRESCALE rewrite while pre_cnt exceeds the new value
        bus_write(6'h04, 32'd7);
        bus_read(6'h07, rd);
        p0   = rd[15:8];
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(posedge clk); #1;
            if (readdata[15:8] !== p0) seen = 1'b1;
        end
        check("presc7_tick_seen", {31'd0, seen}, 32'h1);
        repeat (5) @(posedge clk);
        bus_write(6'h04, 32'd2);
        bus_read(6'h07, rd);
        p0 = rd[15:8];
        @(posedge clk); #1;
        check("presc_w1", {24'd0, readdata[15:8]}, {24'd0, p0});
        @(posedge clk); #1;
        check("presc_w2", {24'd0, readdata[15:8]}, {24'd0, p0});
        @(posedge clk); #1;
        check("presc_w3", {24'd0, readdata[15:8]}, {24'd0, p0 + 8'd1});
        @(posedge clk); @(posedge clk); #1;
        check("presc_w5", {24'd0, readdata[15:8]}, {24'd0, p0 + 8'd1});
        @(posedge clk); #1;
        check("presc_w6", {24'd0, readdata[15:8]}, {24'd0, p0 + 8'd2});

        // Unmapped addresses
        bus_write(6'h28, 32'h5A);
        bus_read(6'h06, rd); check("unmapped_06", rd, 32'h0);
        bus_read(6'h28, rd); check("unmapped_28", rd, 32'h0);

        // Asynchronous reset with LEDs lit and blink running
        bus_write(6'h04, 32'd0);
        bus_write(6'h03, 32'h00);
        bus_write(6'h00, 32'hFF);
        @(posedge clk); #1;
        check("pre_rst_out", {24'd0, out_port}, 32'hFF);
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        check("async_rst_out", {24'd0, out_port}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        bus_read(6'h07, rd); check("post_rst_status", rd, 32'h1);
        bus_read(6'h00, rd); check("post_rst_data", rd, 32'h0);
        bus_read(6'h03, rd); check("post_rst_blink", rd, 32'h0);
        bus_read(6'h04, rd); check("post_rst_presc", rd, 32'h0);
        bus_read(6'h05, rd); check("post_rst_bhalf", rd, 32'h0);
        @(posedge clk); #1;
        bus_read(6'h22, rd); check("post_rst_bright2", rd, 32'hFF);
        bus_read(6'h27, rd); check("post_rst_bright7", rd, 32'hFF);
        check("post_rst_out", {24'd0, out_port}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
